// File: rtl/node_eval.sv
// node_eval: per-node weighted-sum datapath for the tree walker.
// Accumulates coeff*x over all features, then decides the child direction.
module node_eval #(
    parameter  int FEATURES          = 3,
    parameter  int FEATURE_BIT_DEPTH = 8,
    parameter  int COEFF_BIT_DEPTH   = 4,
    parameter  int BIAS_BIT_DEPTH    = 10,
    localparam int IW                = $clog2(FEATURES)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  i_sample_valid,
    output logic                                  o_sample_ready,
    input  logic [FEATURES*FEATURE_BIT_DEPTH-1:0] i_sample,
    output logic [IW-1:0]                         o_feat_idx,
    input  logic [COEFF_BIT_DEPTH-1:0]            i_coeff,
    input  logic                                  i_is_one,
    input  logic [BIAS_BIT_DEPTH-1:0]             i_bias,
    input  logic                                  i_tree_done,
    input  logic [IW-1:0]                         i_path,
    output logic                                  o_next,
    output logic                                  o_child_direction,
    output logic                                  o_class_valid,
    output logic [IW-1:0]                         o_class_path
);

    localparam int FB    = FEATURE_BIT_DEPTH;
    localparam int CB    = COEFF_BIT_DEPTH;
    localparam int BB    = BIAS_BIT_DEPTH;
    localparam int ACC_W = FB + CB + IW + 1;
    localparam int CMP_W = ((ACC_W > BB) ? ACC_W : BB) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_COMPARE,
        S_WAIT
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;
    logic [FEATURES*FB-1:0]       r_sample;
    logic signed [ACC_W-1:0]      r_acc;
    logic [IW-1:0]                r_feat_idx;
    logic                         r_child_dir;
    logic                         r_class_valid;
    logic [IW-1:0]                r_class_path;

    logic signed [FB-1:0]         w_x;
    logic signed [FB+CB-1:0]      w_prod;
    logic signed [ACC_W-1:0]      w_term;
    logic signed [CMP_W-1:0]      w_acc_ext;
    logic signed [CMP_W-1:0]      w_bias_ext;
    logic                         w_ge;
    logic                         w_last;

    always_comb begin
        w_x = '0;
        for (int k = 0; k < FEATURES; k++) begin
            if (r_feat_idx == IW'(k)) begin
                w_x = r_sample[k*FB +: FB];
            end
        end
    end

    assign w_prod = w_x * $signed(i_coeff);

    // is_one bypasses the multiplier so a +1 weight needs no coeff encoding
    assign w_term = i_is_one
        ? {{(ACC_W-FB){w_x[FB-1]}}, w_x}
        : {{(ACC_W-FB-CB){w_prod[FB+CB-1]}}, w_prod};

    assign w_acc_ext  = {{(CMP_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
    assign w_bias_ext = {{(CMP_W-BB){i_bias[BB-1]}}, i_bias};
    assign w_ge       = (w_acc_ext >= w_bias_ext);
    assign w_last     = (r_feat_idx == IW'(FEATURES-1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        o_sample_ready = 1'b0;
        o_next         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                o_sample_ready = 1'b1;
                if (i_sample_valid) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_last) begin
                    w_state_nxt = S_COMPARE;
                end
            end
            S_COMPARE: begin
                o_next      = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_state_nxt = i_tree_done ? S_IDLE : S_ACCUM;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample      <= '0;
            r_acc         <= '0;
            r_feat_idx    <= '0;
            r_child_dir   <= 1'b0;
            r_class_valid <= 1'b0;
            r_class_path  <= '0;
        end else begin
            r_class_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_sample_valid) begin
                        r_sample   <= i_sample;
                        r_acc      <= '0;
                        r_feat_idx <= '0;
                    end
                end
                S_ACCUM: begin
                    r_acc      <= r_acc + w_term;
                    r_feat_idx <= w_last ? '0 : r_feat_idx + 1'b1;
                end
                S_COMPARE: begin
                    r_child_dir <= w_ge;
                end
                S_WAIT: begin
                    if (i_tree_done) begin
                        r_class_path  <= i_path;
                        r_class_valid <= 1'b1;
                    end else begin
                        r_acc      <= '0;
                        r_feat_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // direction is live alongside next, then held until the next compare
    assign o_child_direction = (r_state == S_COMPARE) ? w_ge : r_child_dir;
    assign o_feat_idx        = r_feat_idx;
    assign o_class_valid     = r_class_valid;
    assign o_class_path      = r_class_path;

endmodule

// File: tb/tb_node_eval.sv
// tb_node_eval: randomized scoreboard bench for node_eval.
// Drives whole trees, predicts decisions with integer math, monitors pulses.
module tb_node_eval;

    localparam int F  = 3;
    localparam int FB = 8;
    localparam int CB = 4;
    localparam int BB = 10;
    localparam int IW = 2;

    logic              clk;
    logic              reset;
    logic              i_sample_valid;
    logic              o_sample_ready;
    logic [F*FB-1:0]   i_sample;
    logic [IW-1:0]     o_feat_idx;
    logic [CB-1:0]     i_coeff;
    logic              i_is_one;
    logic [BB-1:0]     i_bias;
    logic              i_tree_done;
    logic [IW-1:0]     i_path;
    logic              o_next;
    logic              o_child_direction;
    logic              o_class_valid;
    logic [IW-1:0]     o_class_path;

    node_eval #(
        .FEATURES(F),
        .FEATURE_BIT_DEPTH(FB),
        .COEFF_BIT_DEPTH(CB),
        .BIAS_BIT_DEPTH(BB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_sample_valid(i_sample_valid),
        .o_sample_ready(o_sample_ready),
        .i_sample(i_sample),
        .o_feat_idx(o_feat_idx),
        .i_coeff(i_coeff),
        .i_is_one(i_is_one),
        .i_bias(i_bias),
        .i_tree_done(i_tree_done),
        .i_path(i_path),
        .o_next(o_next),
        .o_child_direction(o_child_direction),
        .o_class_valid(o_class_valid),
        .o_class_path(o_class_path)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int dir; int cyc; } nexp_t;
    typedef struct { int path; int cyc; } cexp_t;

    nexp_t nq[$];
    cexp_t cq[$];
    nexp_t ne;
    cexp_t ce;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int last_path = 0;

    logic [CB-1:0] c_coeff[4];
    logic          c_one[4];
    assign i_coeff  = c_coeff[o_feat_idx];
    assign i_is_one = c_one[o_feat_idx];

    int t_x[F];
    int t_cf[8][F];
    bit t_one[8][F];
    int t_bias[8];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int node_sum(input int n);
        int s = 0;
        for (int k = 0; k < F; k++) begin
            s += t_one[n][k] ? t_x[k] : t_x[k] * t_cf[n][k];
        end
        return s;
    endfunction

    task automatic load_node(input int n);
        for (int k = 0; k < F; k++) begin
            c_coeff[k] = CB'(t_cf[n][k]);
            c_one[k]   = t_one[n][k];
        end
        i_bias = BB'(t_bias[n]);
    endtask

    function automatic logic [F*FB-1:0] pack_x();
        logic [F*FB-1:0] v = '0;
        for (int k = 0; k < F; k++) v[k*FB +: FB] = FB'(t_x[k]);
        return v;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (o_next) begin
                if (nq.size() == 0) begin
                    chk("next_unexpected", 1, int'(nq.size()));
                end else begin
                    ne = nq.pop_front();
                    chk("child_direction", o_child_direction, ne.dir);
                    chk("next_timing", cyc, ne.cyc);
                end
            end
            if (o_class_valid) begin
                if (cq.size() == 0) begin
                    chk("class_unexpected", 1, int'(cq.size()));
                end else begin
                    ce = cq.pop_front();
                    chk("class_path", o_class_path, ce.path);
                    chk("class_timing", cyc, ce.cyc);
                    chk("ready_at_class", o_sample_ready, 1);
                end
            end
        end
    end

    task automatic run_tree(input int nn, input int path, input bit noise);
        int acc_cyc;
        int dir;
        @(negedge clk);
        chk("class_path_hold", o_class_path, last_path);
        chk("ready_idle", o_sample_ready, 1);
        load_node(0);
        i_sample       = pack_x();
        i_sample_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        for (int i = 0; i < nn; i++) begin
            ne.dir = (node_sum(i) >= t_bias[i]) ? 1 : 0;
            ne.cyc = acc_cyc + 3 + 5 * i;
            nq.push_back(ne);
        end
        ce.path = path;
        ce.cyc  = acc_cyc + 5 * nn;
        cq.push_back(ce);
        i_sample_valid = 1'b0;
        for (int i = 0; i < nn; i++) begin
            dir = (node_sum(i) >= t_bias[i]) ? 1 : 0;
            for (int t = 0; t < 4; t++) begin
                if (noise) begin
                    i_tree_done    = 1'($urandom);
                    i_sample_valid = 1'($urandom);
                    i_sample       = (F*FB)'($urandom);
                    i_path         = IW'($urandom);
                end
                chk("ready_busy", o_sample_ready, 0);
                @(posedge clk);
                #1;
            end
            chk("direction_held", o_child_direction, dir);
            chk("ready_wait", o_sample_ready, 0);
            if (i + 1 < nn) load_node(i + 1);
            i_tree_done    = (i + 1 == nn);
            i_path         = (i + 1 == nn) ? IW'(path) : IW'($urandom);
            i_sample_valid = noise;
            @(posedge clk);
            #1;
            i_tree_done    = 1'b0;
            i_sample_valid = 1'b0;
        end
        chk("ready_after_tree", o_sample_ready, 1);
        last_path = path;
    endtask

    task automatic rand_tree(input int nn);
        for (int k = 0; k < F; k++) t_x[k] = int'($urandom_range(0, 255)) - 128;
        for (int n = 0; n < nn; n++) begin
            int s;
            for (int k = 0; k < F; k++) begin
                t_cf[n][k]  = int'($urandom_range(0, 15)) - 8;
                t_one[n][k] = ($urandom_range(0, 3) == 0);
            end
            s = node_sum(n);
            if (s > -511 && s < 510 && $urandom_range(0, 1) == 1)
                t_bias[n] = s + int'($urandom_range(0, 2)) - 1;
            else
                t_bias[n] = int'($urandom_range(0, 1023)) - 512;
        end
    endtask

    task automatic set_node(input int n, input int c, input bit one, input int b);
        for (int k = 0; k < F; k++) begin
            t_cf[n][k]  = c;
            t_one[n][k] = one;
        end
        t_bias[n] = b;
    endtask

    initial begin
        reset          = 1'b1;
        i_sample_valid = 1'b0;
        i_sample       = '0;
        i_bias         = '0;
        i_tree_done    = 1'b0;
        i_path         = '0;
        for (int k = 0; k < 4; k++) begin
            c_coeff[k] = '0;
            c_one[k]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_ready", o_sample_ready, 1);
        chk("rst_next", o_next, 0);
        chk("rst_dir", o_child_direction, 0);
        chk("rst_class_valid", o_class_valid, 0);
        chk("rst_class_path", o_class_path, 0);
        chk("rst_feat_idx", o_feat_idx, 0);

        t_x[0] = 10; t_x[1] = 20; t_x[2] = 30;
        set_node(0, 1, 1'b0, 60);
        run_tree(1, 1, 1'b0);
        set_node(0, 1, 1'b0, 61);
        run_tree(1, 3, 1'b0);

        t_x[0] = -128; t_x[1] = -128; t_x[2] = -128;
        set_node(0, -8, 1'b0, 511);
        run_tree(1, 0, 1'b0);

        t_x[0] = 5; t_x[1] = -7; t_x[2] = 9;
        set_node(0, -8, 1'b1, 7);
        run_tree(1, 1, 1'b0);

        t_x[0] = 10; t_x[1] = 20; t_x[2] = 30;
        set_node(0, 1, 1'b0, 60);
        set_node(1, 1, 1'b0, 61);
        run_tree(2, 2, 1'b1);

        @(negedge clk);
        load_node(0);
        i_sample       = pack_x();
        i_sample_valid = 1'b1;
        @(posedge clk);
        #1;
        i_sample_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst_ready", o_sample_ready, 1);
        chk("midrst_next", o_next, 0);
        chk("midrst_dir", o_child_direction, 0);
        chk("midrst_class_valid", o_class_valid, 0);
        chk("midrst_feat_idx", o_feat_idx, 0);
        last_path = 0;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_idle", o_sample_ready, 1);

        for (int r = 0; r < 40; r++) begin
            int nn;
            nn = int'($urandom_range(1, 4));
            rand_tree(nn);
            run_tree(nn, int'($urandom_range(0, 3)), 1'($urandom));
        end

        repeat (8) @(posedge clk);
        #1;
        chk("next_queue_drained", int'(nq.size()), 0);
        chk("class_queue_drained", int'(cq.size()), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
